// File: rtl/lane_deserializer.sv
// Per-lane serial-to-parallel receive front end: hunts for idle-word alignment,
// confirms lock over N_LOCK aligned idles, then presents 32-bit data words.
module lane_deserializer #(
  parameter logic [31:0] IDLE_WORD = 32'hBCF7F7F7,
  parameter int unsigned N_LOCK    = 4
) (
  input  logic        clk_32f,
  input  logic        reset,
  input  logic        serial_in,
  output logic [31:0] lane_out,
  output logic        valid_out,
  output logic        active
);

  generate
    if (N_LOCK < 2 || N_LOCK > 15) begin : g_bad_n_lock
      $error("lane_deserializer: N_LOCK must be in 2..15");
    end
  endgenerate

  localparam logic [3:0] N_LOCK_C = 4'(N_LOCK);

  typedef enum logic [1:0] {
    HUNT,
    LOCKING,
    ACTIVE
  } state_t;

  state_t      state, state_nx;
  // Only the low 31 bits are retained: bit 31 falls out of every window.
  logic [30:0] sr;
  logic [31:0] w;
  logic [4:0]  cnt, cnt_nx;
  logic [3:0]  idle_cnt, idle_cnt_nx;
  logic [31:0] lane_nx;
  logic        valid_nx, active_nx;
  logic        is_idle, boundary;

  assign w        = {sr, serial_in};
  assign is_idle  = (w == IDLE_WORD);
  assign boundary = (cnt == 5'd31);

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state     <= HUNT;
      sr        <= '0;
      cnt       <= '0;
      idle_cnt  <= '0;
      lane_out  <= '0;
      valid_out <= 1'b0;
      active    <= 1'b0;
    end else begin
      state     <= state_nx;
      sr        <= w[30:0];
      cnt       <= cnt_nx;
      idle_cnt  <= idle_cnt_nx;
      lane_out  <= lane_nx;
      valid_out <= valid_nx;
      active    <= active_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt + 5'd1;
    idle_cnt_nx = idle_cnt;
    lane_nx     = lane_out;
    valid_nx    = valid_out;
    active_nx   = active;
    case (state)
      HUNT: begin
        if (is_idle) begin
          // Next edge sees cnt=0, so cnt=31 lands on the next aligned word end.
          cnt_nx      = '0;
          idle_cnt_nx = 4'd1;
          state_nx    = LOCKING;
        end
      end
      LOCKING: begin
        if (boundary) begin
          if (is_idle) begin
            idle_cnt_nx = idle_cnt + 4'd1;
            if (idle_cnt + 4'd1 == N_LOCK_C) begin
              state_nx  = ACTIVE;
              active_nx = 1'b1;
            end
          end else begin
            idle_cnt_nx = '0;
            state_nx    = HUNT;
          end
        end
      end
      ACTIVE: begin
        if (boundary) begin
          if (is_idle) begin
            valid_nx = 1'b0;
          end else begin
            lane_nx  = w;
            valid_nx = 1'b1;
          end
        end
      end
      default: state_nx = HUNT;
    endcase
  end

endmodule

// File: tb/tb_lane_deserializer.sv
// Directed bench for lane_deserializer: stimulus pushes expected data words into
// a queue, a monitor pops and compares them as the DUT presents new words.
module tb_lane_deserializer;

  localparam logic [31:0] IDLE = 32'hBCF7F7F7;

  logic        clk_32f;
  logic        reset;
  logic        serial_in;
  logic [31:0] lane_out, lane_out2;
  logic        valid_out, valid_out2;
  logic        active, active2;

  int checks;
  int errors;
  logic [31:0] exp_q[$];

  lane_deserializer #(.IDLE_WORD(IDLE), .N_LOCK(4)) dut (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .serial_in(serial_in),
    .lane_out (lane_out),
    .valid_out(valid_out),
    .active   (active)
  );

  lane_deserializer #(.IDLE_WORD(IDLE), .N_LOCK(2)) dut2 (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .serial_in(serial_in),
    .lane_out (lane_out2),
    .valid_out(valid_out2),
    .active   (active2)
  );

  initial begin
    clk_32f = 1'b0;
    forever #5 clk_32f = ~clk_32f;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Caller always sits just after a negedge; the following posedge samples b.
  task automatic send_bit(input logic b);
    serial_in = b;
    @(negedge clk_32f);
  endtask

  // Optionally checks that outputs stay at the given values for the first 31 bits.
  task automatic send_word(input logic [31:0] wd, input bit hold,
                           input logic [31:0] h_lane, input logic h_valid, input logic h_active);
    for (int i = 31; i >= 0; i--) begin
      send_bit(wd[i]);
      if (hold && i != 0) begin
        check("hold_lane", lane_out, h_lane);
        check("hold_valid", {31'b0, valid_out}, {31'b0, h_valid});
        check("hold_active", {31'b0, active}, {31'b0, h_active});
      end
    end
  endtask

  task automatic send_idle();
    send_word(IDLE, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int unsigned n);
    reset = 1'b1;
    repeat (n) @(negedge clk_32f);
    reset = 1'b0;
  endtask

  // Monitor: quiet outputs while unlocked; scoreboard compare on each new data word.
  initial begin
    logic        prev_valid;
    logic [31:0] prev_lane;
    prev_valid = 1'b0;
    prev_lane  = '0;
    forever begin
      @(negedge clk_32f);
      if (!active) begin
        check("quiet_lane", lane_out, '0);
        check("quiet_valid", {31'b0, valid_out}, '0);
      end
      if (valid_out && (!prev_valid || lane_out != prev_lane)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard: got unexpected word %h expected none at %0t", lane_out, $time);
        end else begin
          check("scoreboard", lane_out, exp_q.pop_front());
        end
      end
      prev_valid = valid_out;
      prev_lane  = lane_out;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [12:0] prefix;
    checks    = 0;
    errors    = 0;
    serial_in = 1'b0;
    reset     = 1'b1;
    @(negedge clk_32f);

    // Aligned lock from reset; N_LOCK=2 instance locks after two idles
    do_reset(3);
    check("rst_lane", lane_out, '0);
    check("rst_valid", {31'b0, valid_out}, '0);
    check("rst_active", {31'b0, active}, '0);
    send_idle();
    check("lock1_active", {31'b0, active}, '0);
    check("n2_lock1_active", {31'b0, active2}, '0);
    send_idle();
    check("lock2_active", {31'b0, active}, '0);
    check("n2_lock2_active", {31'b0, active2}, 32'd1);
    send_idle();
    check("lock3_active", {31'b0, active}, '0);
    send_word(IDLE, 1'b1, '0, 1'b0, 1'b0);
    check("lock4_active", {31'b0, active}, 32'd1);
    check("lock4_lane", lane_out, '0);
    check("lock4_valid", {31'b0, valid_out}, '0);
    check("n2_lane", lane_out2, '0);
    check("n2_valid", {31'b0, valid_out2}, '0);

    // Data words held a full word period, idle drops valid but keeps lane
    exp_q.push_back(32'hDEADBEEF);
    send_word(32'hDEADBEEF, 1'b1, '0, 1'b0, 1'b1);
    check("data1_valid", {31'b0, valid_out}, 32'd1);
    check("data1_lane", lane_out, 32'hDEADBEEF);
    exp_q.push_back(32'h01234567);
    send_word(32'h01234567, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1);
    check("data2_lane", lane_out, 32'h01234567);
    send_word(IDLE, 1'b1, 32'h01234567, 1'b1, 1'b1);
    check("idle_valid", {31'b0, valid_out}, '0);
    check("idle_lane", lane_out, 32'h01234567);

    // Reset mid-word, then relock
    for (int i = 0; i < 11; i++) send_bit(i[0]);
    do_reset(1);
    check("midrst_active", {31'b0, active}, '0);
    check("midrst_valid", {31'b0, valid_out}, '0);
    check("midrst_lane", lane_out, '0);
    send_idle();
    send_idle();
    send_idle();
    check("relock3_active", {31'b0, active}, '0);
    send_idle();
    check("relock4_active", {31'b0, active}, 32'd1);
    exp_q.push_back(32'hAAAA5555);
    send_word(32'hAAAA5555, 1'b0, '0, 1'b0, 1'b0);
    check("relock_lane", lane_out, 32'hAAAA5555);

    // Misaligned start: 13-bit prefix, alignment found on the idle stream
    do_reset(2);
    prefix = 13'b1011001110100;
    for (int i = 12; i >= 0; i--) send_bit(prefix[i]);
    send_idle();
    send_idle();
    send_idle();
    check("pre_lock3_active", {31'b0, active}, '0);
    send_idle();
    check("pre_lock4_active", {31'b0, active}, 32'd1);
    exp_q.push_back(32'hCAFEF00D);
    send_word(32'hCAFEF00D, 1'b0, '0, 1'b0, 1'b0);
    check("pre_lane", lane_out, 32'hCAFEF00D);
    check("pre_valid", {31'b0, valid_out}, 32'd1);

    // Lock rejection: non-idle at a LOCKING boundary restarts the hunt
    do_reset(2);
    send_idle();
    send_idle();
    send_word(32'h00000000, 1'b0, '0, 1'b0, 1'b0);
    check("rej_active", {31'b0, active}, '0);
    send_idle();
    send_idle();
    send_idle();
    check("rej_relock3_active", {31'b0, active}, '0);
    send_idle();
    check("rej_relock4_active", {31'b0, active}, 32'd1);
    exp_q.push_back(32'h13579BDF);
    send_word(32'h13579BDF, 1'b0, '0, 1'b0, 1'b0);
    check("rej_lane", lane_out, 32'h13579BDF);

    repeat (3) @(negedge clk_32f);
    check("queue_empty", exp_q.size(), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
